// File: rtl/seven_seg_capture.sv
// seven_seg_capture: decodes the multiplexed 7-seg bus into per-position digits.
// Optional hex glyphs (A-F) are enabled by defining SEG_DECODE_HEX_EN.
module seven_seg_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  dp,
  output logic        update,
  output logic [1:0]  upd_idx,
  output logic        pattern_err,
  output logic        anode_err
);

  logic [7:0]       s_seg;
  logic [3:0]       s_an;
  logic [11:0]      p_key;
  logic             s_ok;
  logic             p_ok;
  logic [CNT_W-1:0] cnt;
  logic             same;
  logic             commit;
  logic [2:0]       nz;
  logic [1:0]       idx;
  logic [4:0]       dec;

  // {hit, value}; hit=0 means the glyph is not a digit
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h0F;
    case (p)
      7'h40: r = 5'h10;
      7'h79: r = 5'h11;
      7'h24: r = 5'h12;
      7'h30: r = 5'h13;
      7'h19: r = 5'h14;
      7'h12: r = 5'h15;
      7'h02: r = 5'h16;
      7'h78: r = 5'h17;
      7'h00: r = 5'h18;
      7'h10: r = 5'h19;
`ifdef SEG_DECODE_HEX_EN
      7'h08: r = 5'h1A;
      7'h03: r = 5'h1B;
      7'h46: r = 5'h1C;
      7'h21: r = 5'h1D;
      7'h06: r = 5'h1E;
      7'h0E: r = 5'h1F;
`endif
      default: r = 5'h0F;
    endcase
    return r;
  endfunction

  // p_ok gates the first compare after reset so cleared regs never look like a run
  assign same   = p_ok && ({s_an, s_seg} == p_key);
  assign commit = same && (cnt == CNT_W'(STABLE_CYCLES - 2));
  assign dec    = decode(s_seg[6:0]);

  // count lit anodes and remember which one
  always_comb begin
    nz  = 3'd0;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!s_an[i]) begin
        nz  = nz + 3'd1;
        idx = 2'(i);
      end
    end
  end

  // input sampling and run-length counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_seg <= '0;
      s_an  <= '0;
      p_key <= '0;
      s_ok  <= 1'b0;
      p_ok  <= 1'b0;
      cnt   <= '0;
    end else begin
      s_seg <= seg_in;
      s_an  <= an_in;
      p_key <= {s_an, s_seg};
      s_ok  <= 1'b1;
      p_ok  <= s_ok;
      if (!same)
        cnt <= '0;
      else if (cnt < CNT_W'(STABLE_CYCLES))
        cnt <= cnt + 1'b1;
    end
  end

  // commit a stable run into the display image
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= 16'hFFFF;
      digit_valid <= '0;
      dp          <= '0;
      update      <= 1'b0;
      upd_idx     <= '0;
      pattern_err <= 1'b0;
      anode_err   <= 1'b0;
    end else begin
      update      <= 1'b0;
      pattern_err <= 1'b0;
      anode_err   <= 1'b0;
      if (commit) begin
        if (nz >= 3'd2) begin
          anode_err <= 1'b1;
        end else if (nz == 3'd1) begin
          update      <= 1'b1;
          upd_idx     <= idx;
          dp[idx]     <= ~s_seg[7];
          if (dec[4]) begin
            digits[4*idx +: 4] <= dec[3:0];
            digit_valid[idx]   <= 1'b1;
          end else if (s_seg[6:0] == 7'h7F) begin
            digits[4*idx +: 4] <= 4'hF;
            digit_valid[idx]   <= 1'b0;
          end else begin
            digit_valid[idx] <= 1'b0;
            pattern_err      <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: table, directed and random checks
// against a history-based reference model.
module tb_seven_seg_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  dp;
  logic        update;
  logic [1:0]  upd_idx;
  logic        pattern_err;
  logic        anode_err;

  seven_seg_capture #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .digits(digits), .digit_valid(digit_valid), .dp(dp),
    .update(update), .upd_idx(upd_idx),
    .pattern_err(pattern_err), .anode_err(anode_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_upd, n_perr, n_aerr, first_upd;

  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_dp;
  logic        m_upd, m_perr, m_aerr;
  logic [1:0]  m_idx;
  logic [13:0] hist [0:5];

  logic [6:0] pats [0:15];
  int         npats;

  typedef struct {
    logic [3:0] an;
    logic       dpl;
    logic [6:0] pat;
    int         pos;
    logic [3:0] d;
    logic       v;
    logic       pe;
  } vec_t;
  vec_t tbl[$];

  task automatic m_clear();
    m_digits = 16'hFFFF;
    m_valid  = '0;
    m_dp     = '0;
    m_upd    = 1'b0;
    m_perr   = 1'b0;
    m_aerr   = 1'b0;
    m_idx    = '0;
  endtask

  task automatic m_commit(input logic [11:0] v);
    logic [3:0] a;
    logic [7:0] s;
    int zeros, pos, hit;
    a = v[11:8];
    s = v[7:0];
    zeros = 0;
    pos = 0;
    for (int i = 0; i < 4; i++)
      if (a[i] == 1'b0) begin
        zeros++;
        pos = i;
      end
    if (zeros >= 2) m_aerr = 1'b1;
    else if (zeros == 1) begin
      m_upd = 1'b1;
      m_idx = 2'(pos);
      m_dp[pos] = ~s[7];
      hit = -1;
      for (int k = 0; k < npats; k++)
        if (pats[k] == s[6:0]) hit = k;
      if (hit >= 0) begin
        m_digits[4*pos +: 4] = 4'(hit);
        m_valid[pos] = 1'b1;
      end else if (s[6:0] == 7'h7F) begin
        m_digits[4*pos +: 4] = 4'hF;
        m_valid[pos] = 1'b0;
      end else begin
        m_valid[pos] = 1'b0;
        m_perr = 1'b1;
      end
    end
  endtask

  // a value commits when the last four samples match and the one before differs
  task automatic edge_model();
    for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = rst ? 14'h0 : {2'b01, an_in, seg_in};
    m_upd = 1'b0;
    m_perr = 1'b0;
    m_aerr = 1'b0;
    if (rst) m_clear();
    else if (hist[1][12] && hist[1] == hist[2] && hist[2] == hist[3]
             && hist[3] == hist[4] && hist[4] != hist[5])
      m_commit(hist[1][11:0]);
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_all();
    chk("digits", digits, m_digits);
    chk("digit_valid", {12'b0, digit_valid}, {12'b0, m_valid});
    chk("dp", {12'b0, dp}, {12'b0, m_dp});
    chk("update", {15'b0, update}, {15'b0, m_upd});
    chk("pattern_err", {15'b0, pattern_err}, {15'b0, m_perr});
    chk("anode_err", {15'b0, anode_err}, {15'b0, m_aerr});
    if (m_upd) chk("upd_idx", {14'b0, upd_idx}, {14'b0, m_idx});
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      edge_model();
      #1;
      chk_all();
      if (update) begin
        n_upd++;
        if (first_upd < 0) first_upd = cyc;
      end
      if (pattern_err) n_perr++;
      if (anode_err) n_aerr++;
    end
  endtask

  task automatic clr_cnt();
    n_upd = 0;
    n_perr = 0;
    n_aerr = 0;
    first_upd = -1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [7:0] s);
    an_in = a;
    seg_in = s;
  endtask

  task automatic mid_reset();
    #3;
    rst = 1'b1;
    #1;
    m_clear();
    chk_all();
  endtask

  task automatic add(input logic [3:0] a, input logic dl, input logic [6:0] p,
                     input int pos, input logic [3:0] d, input logic v,
                     input logic pe);
    vec_t t;
    t.an = a; t.dpl = dl; t.pat = p; t.pos = pos;
    t.d = d; t.v = v; t.pe = pe;
    tbl.push_back(t);
  endtask

  initial begin
    int t0;
    logic [3:0] anl [0:7];
    logic [6:0] rp;
    pats[0] = 7'h40; pats[1] = 7'h79; pats[2] = 7'h24; pats[3] = 7'h30;
    pats[4] = 7'h19; pats[5] = 7'h12; pats[6] = 7'h02; pats[7] = 7'h78;
    pats[8] = 7'h00; pats[9] = 7'h10; pats[10] = 7'h08; pats[11] = 7'h03;
    pats[12] = 7'h46; pats[13] = 7'h21; pats[14] = 7'h06; pats[15] = 7'h0E;
`ifdef SEG_DECODE_HEX_EN
    npats = 16;
`else
    npats = 10;
`endif
    anl[0] = 4'hE; anl[1] = 4'hD; anl[2] = 4'hB; anl[3] = 4'h7;
    anl[4] = 4'hF; anl[5] = 4'hC; anl[6] = 4'h0; anl[7] = 4'h6;
    for (int i = 0; i < 6; i++) hist[i] = '0;
    clr_cnt();
    m_clear();
    rst = 1'b1;
    drive(4'hF, 8'hFF);
    step(2);
    rst = 1'b0;
    step(3);

    // async reset mid-clock after some activity
    drive(4'hE, 8'hF9);
    step(7);
    mid_reset();
    step(1);
    rst = 1'b0;
    drive(4'hF, 8'hFF);
    step(2);

    // single commit, exact latency
    clr_cnt();
    drive(4'hE, 8'hC0);
    t0 = cyc;
    step(10);
    chk("t2_updates", 16'(n_upd), 16'd1);
    chk("t2_latency", 16'(first_upd - t0), 16'd5);
    chk("t2_digit0", {12'b0, digits[3:0]}, 16'h0);
    chk("t2_valid", {12'b0, digit_valid}, 16'h1);

    // toggling never commits
    clr_cnt();
    for (int i = 0; i < 4; i++) begin
      drive(4'hB, (i % 2 == 0) ? 8'h90 : 8'hA4);
      step(3);
    end
    chk("t3_no_update", 16'(n_upd), 16'd0);
    drive(4'hB, 8'h90);
    step(8);
    chk("t3_digit2", {12'b0, digits[11:8]}, 16'h9);

    // dp lit, then blank
    drive(4'hD, 8'h10);
    step(8);
    chk("t4_digit1", {12'b0, digits[7:4]}, 16'h9);
    chk("t4_dp1", {15'b0, dp[1]}, 16'h1);
    clr_cnt();
    drive(4'hD, 8'hFF);
    step(8);
    chk("t4_blank", {12'b0, digits[7:4]}, 16'hF);
    chk("t4_blank_v", {15'b0, digit_valid[1]}, 16'h0);
    chk("t4_no_perr", 16'(n_perr), 16'd0);

    // hex glyph
    clr_cnt();
    drive(4'h7, 8'h88);
    step(8);
`ifdef SEG_DECODE_HEX_EN
    chk("t5_hexA", {12'b0, digits[15:12]}, 16'hA);
    chk("t5_valid3", {15'b0, digit_valid[3]}, 16'h1);
    chk("t5_perr", 16'(n_perr), 16'd0);
`else
    chk("t5_perr", 16'(n_perr), 16'd1);
    chk("t5_upd", 16'(n_upd), 16'd1);
    chk("t5_valid3", {15'b0, digit_valid[3]}, 16'h0);
`endif

    // two anodes low
    clr_cnt();
    drive(4'hC, 8'hC0);
    step(8);
    chk("t6_aerr", 16'(n_aerr), 16'd1);
    chk("t6_no_upd", 16'(n_upd), 16'd0);

    // reset part-way through a run
    clr_cnt();
    drive(4'hE, 8'hF9);
    step(2);
    mid_reset();
    drive(4'hF, 8'hFF);
    step(1);
    rst = 1'b0;
    step(8);
    chk("t6_rst_no_upd", 16'(n_upd), 16'd0);
    chk("t6_rst_digits", digits, 16'hFFFF);

    // table of glyphs across positions
    add(4'hE, 0, 7'h40, 0, 4'h0, 1, 0);
    add(4'hD, 0, 7'h79, 1, 4'h1, 1, 0);
    add(4'hB, 0, 7'h24, 2, 4'h2, 1, 0);
    add(4'h7, 0, 7'h30, 3, 4'h3, 1, 0);
    add(4'hE, 0, 7'h19, 0, 4'h4, 1, 0);
    add(4'hD, 0, 7'h12, 1, 4'h5, 1, 0);
    add(4'hB, 0, 7'h02, 2, 4'h6, 1, 0);
    add(4'h7, 0, 7'h78, 3, 4'h7, 1, 0);
    add(4'hE, 0, 7'h00, 0, 4'h8, 1, 0);
    add(4'hD, 0, 7'h10, 1, 4'h9, 1, 0);
    add(4'hB, 0, 7'h7F, 2, 4'hF, 0, 0);
    add(4'h7, 0, 7'h7E, 3, 4'h7, 0, 1);
    add(4'hE, 1, 7'h40, 0, 4'h0, 1, 0);
`ifdef SEG_DECODE_HEX_EN
    add(4'hD, 0, 7'h08, 1, 4'hA, 1, 0);
    add(4'hB, 0, 7'h46, 2, 4'hC, 1, 0);
`else
    add(4'hD, 0, 7'h08, 1, 4'h9, 0, 1);
    add(4'hB, 0, 7'h46, 2, 4'hF, 0, 1);
`endif
    foreach (tbl[i]) begin
      clr_cnt();
      drive(tbl[i].an, {~tbl[i].dpl, tbl[i].pat});
      step(6);
      chk("tbl_digit", {12'b0, digits[4*tbl[i].pos +: 4]}, {12'b0, tbl[i].d});
      chk("tbl_valid", {15'b0, digit_valid[tbl[i].pos]}, {15'b0, tbl[i].v});
      chk("tbl_dp", {15'b0, dp[tbl[i].pos]}, {15'b0, tbl[i].dpl});
      chk("tbl_perr", 16'(n_perr), {15'b0, tbl[i].pe});
      chk("tbl_upd", 16'(n_upd), 16'd1);
    end

    // random runs of varying length
    for (int r = 0; r < 150; r++) begin
      if ($urandom_range(0, 3) == 0) rp = 7'($urandom);
      else if ($urandom_range(0, 5) == 0) rp = 7'h7F;
      else rp = pats[$urandom_range(0, 15)];
      drive(anl[$urandom_range(0, 7)], {1'($urandom), rp});
      step($urandom_range(1, 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
